// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the VGA path.
// Divides clk into a pixel tick, runs the horizontal/vertical counters and
// drives registered sync outputs aligned with the pixel coordinates.
module vga_sync_gen #(
  parameter int unsigned TICK_DIV = 2,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_ACT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HS_START = H_DISP + H_FP;
  localparam int unsigned HS_END   = H_DISP + H_FP + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISP + V_FP;
  localparam int unsigned VS_END   = V_DISP + V_FP + V_SYNC - 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;

  logic [DIV_W-1:0] w_div_next;
  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic             w_hs_next;
  logic             w_vs_next;

  // Pixel tick fires on the last clk of each pixel period; with TICK_DIV=1 it is always high
  always_comb begin
    w_tick     = (r_div_cnt == DIV_W'(TICK_DIV - 1));
    w_div_next = w_tick ? '0 : r_div_cnt + DIV_W'(1);
  end

  // Next counter values: h advances per tick, v advances when h wraps
  always_comb begin
    w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
    w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (w_tick) begin
      w_h_next = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
      if (w_h_last) begin
        w_v_next = w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end
    end
  end

  // Sync levels decoded from the next counts so they land on the same edge as the coordinates
  always_comb begin
    w_hs_next = ~SYNC_ACT;
    w_vs_next = ~SYNC_ACT;
    if ((w_h_next >= 10'(HS_START)) && (w_h_next <= 10'(HS_END))) begin
      w_hs_next = SYNC_ACT;
    end
    if ((w_v_next >= 10'(VS_START)) && (w_v_next <= 10'(VS_END))) begin
      w_vs_next = SYNC_ACT;
    end
  end

  // Divider, counters and sync registers; reset restarts the frame at (0,0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_hsync   <= ~SYNC_ACT;
      r_vsync   <= ~SYNC_ACT;
    end else begin
      r_div_cnt <= w_div_next;
      r_h_cnt   <= w_h_next;
      r_v_cnt   <= w_v_next;
      r_hsync   <= w_hs_next;
      r_vsync   <= w_vs_next;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign p_tick     = w_tick;
  assign pixel_x    = r_h_cnt;
  assign pixel_y    = r_v_cnt;
  assign video_on   = (r_h_cnt < 10'(H_DISP)) && (r_v_cnt < 10'(V_DISP));
  assign frame_tick = w_tick && w_h_last && w_v_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: three instances (default timing at TICK_DIV=2,
// default timing at TICK_DIV=1, a tiny raster at TICK_DIV=3 with active-high
// sync) compared every cycle against a time-based arithmetic model.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hs[3];
  logic       vs[3];
  logic       von[3];
  logic       pt[3];
  logic       ft[3];
  logic [9:0] px[3];
  logic [9:0] py[3];

  always #5 clk = ~clk;

  vga_sync_gen #(.TICK_DIV(2)) u_def2 (
    .clk(clk), .reset(reset), .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]),
    .p_tick(pt[0]), .pixel_x(px[0]), .pixel_y(py[0]), .frame_tick(ft[0]));

  vga_sync_gen #(.TICK_DIV(1)) u_def1 (
    .clk(clk), .reset(reset), .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]),
    .p_tick(pt[1]), .pixel_x(px[1]), .pixel_y(py[1]), .frame_tick(ft[1]));

  vga_sync_gen #(.TICK_DIV(3), .H_DISP(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_ACT(1'b1)) u_sm3 (
    .clk(clk), .reset(reset), .hsync(hs[2]), .vsync(vs[2]), .video_on(von[2]),
    .p_tick(pt[2]), .pixel_x(px[2]), .pixel_y(py[2]), .frame_tick(ft[2]));

  typedef struct {
    int td, hd, hfp, hsw, hbp, vd, vfp, vsw, vbp;
    bit act;
  } geom_t;

  typedef struct {
    logic [9:0] x, y;
    logic hs, vs, von, pt, ft;
  } exp_t;

  typedef struct {
    longint     tt;
    logic [9:0] x, y;
    logic       hs, vs, von, pt;
  } vec_t;

  longint t;        // clk edges seen since reset was released
  int     n_tests;
  int     n_fail;
  vec_t   tbl[13];
  int     c, va, lo0, lo1, run, hold;

  function automatic geom_t geom(input int k);
    geom_t g;
    case (k)
      0:       g = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      1:       g = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      default: g = '{3, 10, 2, 3, 2, 6, 2, 2, 1, 1'b1};
    endcase
    return g;
  endfunction

  // Expected outputs derived purely from elapsed time since reset release
  function automatic exp_t model(input geom_t g, input longint tt);
    exp_t   e;
    longint ht, vt, n, h, v;
    ht   = g.hd + g.hfp + g.hsw + g.hbp;
    vt   = g.vd + g.vfp + g.vsw + g.vbp;
    n    = tt / g.td;
    h    = n % ht;
    v    = (n / ht) % vt;
    e.x  = 10'(h);
    e.y  = 10'(v);
    e.pt = ((tt % g.td) == g.td - 1);
    e.hs = (h >= g.hd + g.hfp && h < g.hd + g.hfp + g.hsw) ? g.act : !g.act;
    e.vs = (v >= g.vd + g.vfp && v < g.vd + g.vfp + g.vsw) ? g.act : !g.act;
    e.von = (h < g.hd) && (v < g.vd);
    e.ft = e.pt && (h == ht - 1) && (v == vt - 1);
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0d expected %0d", nm, t, got, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e = model(geom(k), t);
      cmp($sformatf("u%0d.pixel_x", k), 32'(px[k]), 32'(e.x));
      cmp($sformatf("u%0d.pixel_y", k), 32'(py[k]), 32'(e.y));
      cmp($sformatf("u%0d.hsync", k), 32'(hs[k]), 32'(e.hs));
      cmp($sformatf("u%0d.vsync", k), 32'(vs[k]), 32'(e.vs));
      cmp($sformatf("u%0d.video_on", k), 32'(von[k]), 32'(e.von));
      cmp($sformatf("u%0d.p_tick", k), 32'(pt[k]), 32'(e.pt));
      cmp($sformatf("u%0d.frame_tick", k), 32'(ft[k]), 32'(e.ft));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) t++;
    #1 check_all();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    t       = 0;

    // Hand-derived points on the first lines of the default-timing, TICK_DIV=2 instance
    tbl[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1279, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1280, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1503, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1504, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1599, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1600, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1601, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{3200, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state, applied asynchronously before any clock edge
    #2 reset = 1'b1;
    #1 check_all();
    cmp("rst.hsync", 32'(hs[0]), 1);
    cmp("rst.vsync", 32'(vs[0]), 1);
    cmp("rst.video_on", 32'(von[0]), 1);
    cmp("rst.p_tick_div2", 32'(pt[0]), 0);
    cmp("rst.p_tick_div1", 32'(pt[1]), 1);
    cmp("rst.hsync_acthigh", 32'(hs[2]), 0);
    repeat (3) step();
    @(negedge clk);
    reset = 1'b0;
    #1 check_all();

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      while (t < tbl[i].tt) step();
      cmp($sformatf("vec%0d.x", i), 32'(px[0]), 32'(tbl[i].x));
      cmp($sformatf("vec%0d.y", i), 32'(py[0]), 32'(tbl[i].y));
      cmp($sformatf("vec%0d.hsync", i), 32'(hs[0]), 32'(tbl[i].hs));
      cmp($sformatf("vec%0d.vsync", i), 32'(vs[0]), 32'(tbl[i].vs));
      cmp($sformatf("vec%0d.video_on", i), 32'(von[0]), 32'(tbl[i].von));
      cmp($sformatf("vec%0d.p_tick", i), 32'(pt[0]), 32'(tbl[i].pt));
    end

    // hsync pulse width: 96 clks per line at TICK_DIV=1, 192 clks at TICK_DIV=2
    lo0 = 0;
    lo1 = 0;
    repeat (800) begin
      step();
      if (!hs[0]) lo0++;
      if (!hs[1]) lo1++;
    end
    cmp("hsync_width_div1", 32'(lo1), 96);
    repeat (800) begin
      step();
      if (!hs[0]) lo0++;
    end
    cmp("hsync_width_div2", 32'(lo0), 192);

    // Frame wrap and frame period on the tiny raster
    c = 0;
    while (!ft[2] && c < 2000) begin
      step();
      c++;
    end
    cmp("frame_tick_seen", 32'(ft[2]), 1);
    cmp("wrap.x", 32'(px[2]), 16);
    cmp("wrap.y", 32'(py[2]), 10);
    step();
    cmp("after_wrap.x", 32'(px[2]), 0);
    cmp("after_wrap.y", 32'(py[2]), 0);
    cmp("frame_tick_one_clk", 32'(ft[2]), 0);
    c  = 1;
    va = (vs[2] === 1'b1) ? 1 : 0;
    while (!ft[2] && c < 2000) begin
      step();
      c++;
      if (vs[2] === 1'b1) va++;
    end
    cmp("frame_period", 32'(c), 561);
    cmp("vsync_width", 32'(va), 102);

    // Reset inside both sync pulses clears everything without a clock edge
    c = 0;
    while (!(px[2] == 10'd13 && py[2] == 10'd8) && c < 3000) begin
      step();
      c++;
    end
    cmp("pre_rst.hsync_active", 32'(hs[2]), 1);
    cmp("pre_rst.vsync_active", 32'(vs[2]), 1);
    @(negedge clk);
    reset = 1'b1;
    t = 0;
    #1;
    cmp("mid_rst.hsync", 32'(hs[2]), 0);
    cmp("mid_rst.vsync", 32'(vs[2]), 0);
    cmp("mid_rst.x", 32'(px[2]), 0);
    cmp("mid_rst.y", 32'(py[2]), 0);
    check_all();
    repeat (2) step();
    @(negedge clk);
    reset = 1'b0;
    #1 check_all();
    step();
    cmp("restart.first_tick", 32'(pt[0]), 1);
    cmp("restart.x_before", 32'(px[0]), 0);
    step();
    cmp("restart.x_after", 32'(px[0]), 1);

    // Random run lengths interleaved with random reset pulses
    for (int i = 0; i < 40; i++) begin
      run  = int'($urandom_range(0, 1500));
      hold = int'($urandom_range(1, 3));
      repeat (run) step();
      @(negedge clk);
      reset = 1'b1;
      t = 0;
      #1 check_all();
      repeat (hold) step();
      @(negedge clk);
      reset = 1'b0;
      #1 check_all();
    end
    repeat (200) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480 @ 60 Hz VGA path. It divides the system clock into a pixel tick, runs the horizontal and vertical counters, and drives `hsync`, `vsync`, `video_on` and the `pixel_x`/`pixel_y` coordinates. The text and graphics pixel generators consume these coordinates and return an RGB value, which the top level gates with `video_on`.

## Interface
Parameters:
- `TICK_DIV`, default 2: system clocks per pixel. 50 MHz clk gives a 25 MHz pixel rate. Legal values are 1 and up.
- `H_DISP`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch.
- `H_SYNC`, default 96: horizontal retrace width.
- `H_BP`, default 48: horizontal back porch.
- `V_DISP`, default 480: visible lines.
- `V_FP`, default 10: vertical front porch.
- `V_SYNC`, default 2: vertical retrace width.
- `V_BP`, default 33: vertical back porch.
- `SYNC_ACT`, default 0: active level of `hsync` and `vsync` (0 = active-low).

Ports:
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `hsync` out 1: horizontal sync, registered.
- `vsync` out 1: vertical sync, registered.
- `video_on` out 1: high while the current pixel is inside the visible area.
- `p_tick` out 1: one-`clk` pulse marking a pixel advance.
- `pixel_x` out 10: current horizontal count, h_cnt.
- `pixel_y` out 10: current vertical count, v_cnt.
- `frame_tick` out 1: one-`clk` pulse on the last pixel of each frame.

## Operation
Derived constants:
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP = 525.

Tick divider:
- `div_cnt` counts 0..TICK_DIV-1 and wraps.
- `p_tick` = (div_cnt == TICK_DIV-1).
- With TICK_DIV=1, `p_tick` is constantly 1 after reset.

Counters (advance only in a `clk` cycle where `p_tick` = 1):
- h_cnt increments. At H_TOTAL-1 it wraps to 0.
- v_cnt increments only when h_cnt wraps. At V_TOTAL-1 it wraps to 0 on that same tick.
- Both counters hold when `p_tick` = 0.
- `pixel_x` = h_cnt and `pixel_y` = v_cnt, taken directly from the registers.

Sync outputs:
- `hsync` is registered from the next value of h_cnt, so it changes in the same `clk` edge as `pixel_x`.
- `hsync` is active while H_DISP+H_FP ≤ h_cnt ≤ H_DISP+H_FP+H_SYNC-1, i.e. 656..751. Otherwise it is at the inactive level.
- `vsync` is built the same way: active while V_DISP+V_FP ≤ v_cnt ≤ V_DISP+V_FP+V_SYNC-1, i.e. 490..491.
- Active level = SYNC_ACT. Inactive level = ~SYNC_ACT.

Other outputs:
- `video_on` = (h_cnt < H_DISP) && (v_cnt < V_DISP). It is combinational from the counter registers.
- `frame_tick` = `p_tick` && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.

Reset values (apply immediately and asynchronously):
- div_cnt = 0, h_cnt = 0, v_cnt = 0.
- `hsync` = `vsync` = ~SYNC_ACT (inactive).
- `p_tick` = 0 when TICK_DIV > 1.
- `video_on` = 1, because (0,0) is a visible pixel.
- `frame_tick` = 0.

Reset mid-frame: all state returns to the reset values at once. After release, the frame restarts at (0,0) with a full first pixel period. No partial sync pulse is extended.

## Timing
- First `p_tick`: TICK_DIV `clk` cycles after `reset` deasserts (cycle index TICK_DIV-1, counting from 0).
- Each pixel lasts TICK_DIV `clk` cycles.
- Each line lasts H_TOTAL×TICK_DIV = 1600 `clk` cycles.
- Each frame lasts V_TOTAL lines = 840 000 `clk` cycles.
- Latency from counter value to sync output: 0 cycles relative to `pixel_x`/`pixel_y`. Both come from registers updated on the same edge.
- `hsync` pulse: exactly H_SYNC pixels = 192 `clk` cycles per line.
- `vsync` pulse: exactly V_SYNC lines, spanning from h_cnt=0 of line 490 to the end of line 491.
- Wrap case at (799,524) with `p_tick`: the next edge sets h_cnt = v_cnt = 0 together. `frame_tick` is high during that `p_tick` cycle.
- No gaps: consecutive frames follow back-to-back.

## Test plan
1. Reset hold, then release. During reset: `pixel_x`=0, `pixel_y`=0, `hsync`=`vsync`=1 (SYNC_ACT=0), `video_on`=1. After release: first `p_tick` at clk 1, and `pixel_x`=1 after clk 2.
2. Run one line with TICK_DIV=2. `hsync` falls when `pixel_x` becomes 656 and rises when it becomes 752, giving 192 clks low. `video_on` drops when `pixel_x` becomes 640. `pixel_y` increments when `pixel_x` wraps 799→0.
3. Run one full frame. `vsync` is low exactly while `pixel_y` ∈ {490, 491}, i.e. 3200 clks. `video_on` is 0 for every `pixel_y` ≥ 480.
4. Check the frame wrap. At (799,524) with `p_tick`, `frame_tick`=1 for exactly one clk and the next coordinates are (0,0). Frame period measured between two `frame_tick` pulses = 840 000 clks.
5. Assert `reset` at (700,491), inside both sync pulses. `hsync` and `vsync` go to 1 and the counters go to 0 without waiting for a clock edge. After release the sequence matches scenario 1.
6. Set TICK_DIV=1. `p_tick` is constantly 1, the line period is 800 clks and the `hsync` pulse is 96 clks.
